mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage. Consumes the ALU result (used as a byte address) and the store data (rt value).
- Performs loads and stores against an internal word-addressed data memory with a fixed multi-cycle access latency. Back-pressures upstream with a stall while an access is in flight.
- Produces a registered writeback bundle (data, destination register, write enable) for the writeback stage. Non-memory operations pass through in one cycle.

Parameters:
- DEPTH, 256, number of 32-bit words in the data memory (power of two).
- AW, 8, word-address width, equal to log2(DEPTH).
- MEM_LATENCY, 2, cycles a memory access holds stall high. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- valid_in  input  1  upstream bundle valid
- mem_read  input  1  load operation
- mem_write  input  1  store operation
- mem_to_reg  input  1  writeback selects memory data (1) or ALU result (0)
- reg_write  input  1  writeback enable carried from control
- alu_result  input  32  ALU result / byte address
- write_data  input  32  store data (rt)
- rd  input  5  destination register
- stall  output  1  upstream must hold its bundle
- valid_out  output  1  writeback bundle valid (one-cycle pulse per op)
- wb_data  output  32  writeback data
- wb_rd  output  5  writeback destination
- wb_reg_write  output  1  writeback enable
- mem_fault  output  1  misaligned access flag. Present only with the optional feature.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, latency counter=0.
  - stall=0, valid_out=0, wb_data=0, wb_rd=0, wb_reg_write=0, mem_fault=0.
  - All memory words are cleared to 0.
- Acceptance: a bundle is accepted at a rising edge where valid_in=1 and stall=0. Call this edge E0.
- stall is a combinational decode of state: 1 exactly while state=BUSY.
- States:
  - IDLE:
    - Accepted op with mem_read=0 and mem_write=0 → stay IDLE.
    - At E0 register valid_out=1, wb_data=alu_result, wb_rd=rd, wb_reg_write=reg_write.
  - IDLE → BUSY:
    - Accepted op with mem_read=1 or mem_write=1.
    - At E0 latch the address word index alu_result[AW+1:2], write_data, rd, reg_write, mem_to_reg and the op type.
    - Load counter with MEM_LATENCY-1. valid_out=0.
  - BUSY:
    - inputs are ignored.
    - Counter decrements each edge.
    - At the edge where counter==0 (E_MEM_LATENCY):
      - A store writes memory.
      - A load reads memory.
      - valid_out=1.
      - wb_data is the memory word if mem_to_reg=1, otherwise the latched alu_result.
      - wb_reg_write=latched reg_write; store forces wb_reg_write=0.
      - Transition to IDLE.
- Latency: a non-memory op is valid 1 edge after acceptance. A memory op is valid MEM_LATENCY edges after acceptance and stall is high for MEM_LATENCY cycles.
- valid_out is high for exactly one cycle per op. wb_data, wb_rd and wb_reg_write hold their values otherwise. Back-to-back non-memory ops give valid_out high every cycle.
- mem_read=1 and mem_write=1 together: treated as a store. Memory is written and wb_reg_write=0.
- Address: the upper bits above AW+1 are ignored, so addresses wrap modulo DEPTH words.
- A store followed by a load to the same word returns the stored value, because ops are serialized.
- Reset asserted during BUSY: the access is aborted and a pending store is not committed. Outputs take their reset values immediately.
- valid_in low in IDLE: valid_out=0 next cycle. No state change.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - A memory op with alu_result[1:0]!=0 still takes the full MEM_LATENCY.
  - A store does not modify memory.
  - A load returns wb_data=0 with wb_reg_write=0.
  - mem_fault=1 for the valid_out cycle; 0 otherwise.
- Undefined: the mem_fault port is absent and alu_result[1:0] is ignored (word-aligned access).

Test Plan:
- Reset, then a non-memory op with alu_result=0x0000_0005, rd=3, reg_write=1 → valid_out next cycle, wb_data=5, wb_rd=3, stall never high.
- Store write_data=0xDEAD_BEEF at alu_result=0x10, then load 0x10 with mem_to_reg=1, rd=7 → stall high 2 cycles per op, load yields wb_data=0xDEADBEEF, wb_rd=7; store's wb_reg_write=0.
- Hold valid_in=1 with changing inputs during BUSY → ignored, and only the accepted op completes.
- Store 0x1234 to alu_result=0x400 (DEPTH=256), then load 0x0 → wraps and returns 0x1234.
- Start a store of 0x55 at 0x20, assert reset in the second BUSY cycle, then load 0x20 → returns 0, and the outputs are 0 during reset.
- With MEM_ALIGN_CHECK_EN: store to 0x22, then load 0x20 → mem_fault=1 on the store's valid_out, memory is unchanged, and the load returns the old value.

Source files
------------

// File: rtl/mem_stage_if.sv
//------------------------------------------------------------------------------
// Module  : mem_stage_if
// Brief   : Execute-to-memory bundle and writeback outputs for mem_stage.
//           mem_fault exists only when MEM_ALIGN_CHECK_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_stage_if;
  logic        valid_in;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  rd;
  logic        stall;
  logic        valid_out;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mem_fault;
`endif

  // Upstream / environment side
  modport master (
`ifdef MEM_ALIGN_CHECK_EN
    input  mem_fault,
`endif
    output valid_in, mem_read, mem_write, mem_to_reg, reg_write,
    output alu_result, write_data, rd,
    input  stall, valid_out, wb_data, wb_rd, wb_reg_write
  );

  modport slave (
`ifdef MEM_ALIGN_CHECK_EN
    output mem_fault,
`endif
    input  valid_in, mem_read, mem_write, mem_to_reg, reg_write,
    input  alu_result, write_data, rd,
    output stall, valid_out, wb_data, wb_rd, wb_reg_write
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// Module  : mem_stage
// Brief   : Memory pipeline stage with multi-cycle internal data memory and
//           registered writeback bundle. Optional macro: MEM_ALIGN_CHECK_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage #(
  parameter int DEPTH       = 256,
  parameter int AW          = 8,
  parameter int MEM_LATENCY = 2
) (
  input  wire logic  clk,
  input  wire logic  reset,
  mem_stage_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] c_lat_load = 4'(MEM_LATENCY - 1);

  state_t        r_state;
  logic [3:0]    r_count;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_alu;
  logic [31:0]   r_wdata;
  logic [4:0]    r_rd;
  logic          r_reg_write;
  logic          r_mem_to_reg;
  logic          r_is_store;
  logic          r_misalign;
  logic [31:0]   r_mem [DEPTH];

  logic          r_valid_out;
  logic [31:0]   r_wb_data;
  logic [4:0]    r_wb_rd;
  logic          r_wb_reg_write;
  logic          r_mem_fault;

  logic          w_stall;
  logic          w_misalign_in;
  logic [31:0]   w_mem_word;

  assign w_stall    = (r_state == BUSY);
  assign w_mem_word = r_mem[r_addr];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign_in = |bus.alu_result[1:0];
  assign bus.mem_fault = r_mem_fault;
`else
  // Without the check every access is treated as word aligned
  assign w_misalign_in = 1'b0;
  logic w_unused_fault;
  assign w_unused_fault = r_mem_fault;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_addr         <= '0;
      r_alu          <= '0;
      r_wdata        <= '0;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_mem_to_reg   <= 1'b0;
      r_is_store     <= 1'b0;
      r_misalign     <= 1'b0;
      r_valid_out    <= 1'b0;
      r_wb_data      <= '0;
      r_wb_rd        <= '0;
      r_wb_reg_write <= 1'b0;
      r_mem_fault    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_valid_out <= 1'b0;
      r_mem_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.valid_in) begin
            if (bus.mem_read || bus.mem_write) begin
              r_addr       <= bus.alu_result[AW+1:2];
              r_alu        <= bus.alu_result;
              r_wdata      <= bus.write_data;
              r_rd         <= bus.rd;
              r_reg_write  <= bus.reg_write;
              r_mem_to_reg <= bus.mem_to_reg;
              // Read+write together behaves as a store
              r_is_store   <= bus.mem_write;
              r_misalign   <= w_misalign_in;
              r_count      <= c_lat_load;
              r_state      <= BUSY;
            end else begin
              r_valid_out    <= 1'b1;
              r_wb_data      <= bus.alu_result;
              r_wb_rd        <= bus.rd;
              r_wb_reg_write <= bus.reg_write;
            end
          end
        end
        BUSY: begin
          if (r_count == 4'd0) begin
            r_state     <= IDLE;
            r_valid_out <= 1'b1;
            r_wb_rd     <= r_rd;
            if (r_misalign) begin
              // Faulting access leaves memory untouched and suppresses writeback
              r_mem_fault    <= 1'b1;
              r_wb_reg_write <= 1'b0;
              r_wb_data      <= r_is_store ? (r_mem_to_reg ? w_mem_word : r_alu) : 32'd0;
            end else begin
              if (r_is_store) begin
                r_mem[r_addr] <= r_wdata;
              end
              r_wb_data      <= r_mem_to_reg ? w_mem_word : r_alu;
              r_wb_reg_write <= r_reg_write & ~r_is_store;
            end
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.stall        = w_stall;
  assign bus.valid_out    = r_valid_out;
  assign bus.wb_data      = r_wb_data;
  assign bus.wb_rd        = r_wb_rd;
  assign bus.wb_reg_write = r_wb_reg_write;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_stage
// Brief   : Directed self-checking bench for mem_stage (MEM_LATENCY=2).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_stage_if bus ();

  mem_stage #(
    .DEPTH       (256),
    .AW          (8),
    .MEM_LATENCY (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic mr, input logic mw, input logic m2r,
                       input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rdv);
    bus.valid_in   = v;
    bus.mem_read   = mr;
    bus.mem_write  = mw;
    bus.mem_to_reg = m2r;
    bus.reg_write  = rw;
    bus.alu_result = addr;
    bus.write_data = wd;
    bus.rd         = rdv;
  endtask

  // Two-cycle memory op: stall during both BUSY cycles, result on the third edge
  task automatic mem_op(input string tag, input logic mr, input logic mw, input logic m2r,
                        input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rdv, input logic [31:0] exp_data,
                        input logic exp_rw, input logic exp_fault);
    drive(1'b1, mr, mw, m2r, rw, addr, wd, rdv);
    tick();
    chk({tag, "_stall1"}, 32'(bus.stall), 32'd1);
    chk({tag, "_nv1"}, 32'(bus.valid_out), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    chk({tag, "_stall2"}, 32'(bus.stall), 32'd1);
    chk({tag, "_nv2"}, 32'(bus.valid_out), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(bus.valid_out), 32'd1);
    chk({tag, "_stall0"}, 32'(bus.stall), 32'd0);
    chk({tag, "_data"}, bus.wb_data, exp_data);
    chk({tag, "_rd"}, 32'(bus.wb_rd), 32'(rdv));
    chk({tag, "_rw"}, 32'(bus.wb_reg_write), 32'(exp_rw));
`ifdef MEM_ALIGN_CHECK_EN
    chk({tag, "_fault"}, 32'(bus.mem_fault), 32'(exp_fault));
`else
    chk({tag, "_nofault"}, 32'(exp_fault), 32'd0);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    tick();
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_data", bus.wb_data, 32'd0);
    chk("rst_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_rw", 32'(bus.wb_reg_write), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("rst_fault", 32'(bus.mem_fault), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // Non-memory pass-through
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0005, 32'h0, 5'd3);
    chk("alu_stall_pre", 32'(bus.stall), 32'd0);
    tick();
    chk("alu_valid", 32'(bus.valid_out), 32'd1);
    chk("alu_data", bus.wb_data, 32'h0000_0005);
    chk("alu_rd", 32'(bus.wb_rd), 32'd3);
    chk("alu_rw", 32'(bus.wb_reg_write), 32'd1);
    chk("alu_stall", 32'(bus.stall), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    chk("idle_valid", 32'(bus.valid_out), 32'd0);
    chk("idle_hold", bus.wb_data, 32'h0000_0005);

    // Back-to-back non-memory ops
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0009, 32'h0, 5'd4);
    tick();
    chk("b2b1_valid", 32'(bus.valid_out), 32'd1);
    chk("b2b1_data", bus.wb_data, 32'h0000_0009);
    chk("b2b1_rw", 32'(bus.wb_reg_write), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_000A, 32'h0, 5'd5);
    tick();
    chk("b2b2_valid", 32'(bus.valid_out), 32'd1);
    chk("b2b2_data", bus.wb_data, 32'h0000_000A);
    chk("b2b2_rd", 32'(bus.wb_rd), 32'd5);

    // Store with changing inputs held valid during BUSY
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd1);
    tick();
    chk("st_stall1", 32'(bus.stall), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0000_0011, 5'd9);
    tick();
    chk("st_stall2", 32'(bus.stall), 32'd1);
    chk("st_nv2", 32'(bus.valid_out), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0048, 32'h0000_0022, 5'd10);
    tick();
    chk("st_valid", 32'(bus.valid_out), 32'd1);
    chk("st_data", bus.wb_data, 32'h0000_0010);
    chk("st_rd", 32'(bus.wb_rd), 32'd1);
    chk("st_rw", 32'(bus.wb_reg_write), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    chk("st_after_valid", 32'(bus.valid_out), 32'd0);
    chk("st_after_stall", 32'(bus.stall), 32'd0);

    mem_op("ld10", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b0);
    mem_op("ld44", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0044, 32'h0, 5'd8, 32'h0000_0000, 1'b1, 1'b0);
    // Load with mem_to_reg=0 returns the address itself
    mem_op("ldalu", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5'd2, 32'h0000_0010, 1'b1, 1'b0);
    // Read+write together acts as a store
    mem_op("rdwr", 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0030, 32'hCAFE_0001, 5'd6, 32'h0000_0030, 1'b0, 1'b0);
    mem_op("ld30", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0030, 32'h0, 5'd11, 32'hCAFE_0001, 1'b1, 1'b0);

    // Address wrap: 0x400 maps to word 0
    mem_op("stwrap", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_1234, 5'd12, 32'h0000_0400, 1'b0, 1'b0);
    mem_op("ldwrap", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0, 5'd13, 32'h0000_1234, 1'b1, 1'b0);

    // Reset during the second BUSY cycle aborts the store
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_0055, 5'd14);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    chk("abort_busy", 32'(bus.stall), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_stall", 32'(bus.stall), 32'd0);
    chk("abort_data", bus.wb_data, 32'd0);
    chk("abort_rd", 32'(bus.wb_rd), 32'd0);
    tick();
    chk("abort_valid", 32'(bus.valid_out), 32'd0);
    reset = 1'b0;
    tick();
    mem_op("ld20", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0, 5'd15, 32'h0000_0000, 1'b1, 1'b0);
    mem_op("ld0clr", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0, 5'd16, 32'h0000_0000, 1'b1, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
    mem_op("al_st20", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_AAAA, 5'd17, 32'h0000_0020, 1'b0, 1'b0);
    mem_op("al_st22", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0022, 32'h0000_0099, 5'd18, 32'h0000_0022, 1'b0, 1'b1);
    mem_op("al_ld20", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0, 5'd19, 32'h0000_AAAA, 1'b1, 1'b0);
    mem_op("al_ld21", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0021, 32'h0, 5'd20, 32'h0000_0000, 1'b0, 1'b1);
    tick();
    chk("al_fault_clr", 32'(bus.mem_fault), 32'd0);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
